// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter_if
//   Bundles the requester side and sink side of the round-robin stream arbiter.
//   slave  : arbiter view (takes requests and sink ready, drives grants/outputs)
//   master : environment view (drives requests and sink ready)
//   Signals:
//     t_data_i[T_AMOUNT] / t_valid_i / t_last_i : per-requester beat
//     t_ready_o                                 : per-requester ready (one-hot or zero)
//     t_data_o / t_valid_o / t_last_o           : registered output beat
//     t_number_o                                : one-hot source of the output beat
//     t_ready_i                                 : sink ready
//     busy_o                                    : a grant is held
interface stream_rr_arbiter_if #(
  parameter int BIT_DEPTH = 8,
  parameter int T_AMOUNT  = 4
);
  logic [BIT_DEPTH-1:0] t_data_i [T_AMOUNT];
  logic [T_AMOUNT-1:0]  t_valid_i;
  logic [T_AMOUNT-1:0]  t_last_i;
  logic [T_AMOUNT-1:0]  t_ready_o;
  logic [BIT_DEPTH-1:0] t_data_o;
  logic                 t_valid_o;
  logic                 t_last_o;
  logic [T_AMOUNT-1:0]  t_number_o;
  logic                 t_ready_i;
  logic                 busy_o;

  modport slave (
    input  t_data_i, t_valid_i, t_last_i, t_ready_i,
    output t_ready_o, t_data_o, t_valid_o, t_last_o, t_number_o, busy_o
  );

  modport master (
    output t_data_i, t_valid_i, t_last_i, t_ready_i,
    input  t_ready_o, t_data_o, t_valid_o, t_last_o, t_number_o, busy_o
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//   Packet-aware round-robin arbiter sharing one valid/ready sink between
//   T_AMOUNT requesters. A granted requester keeps the sink until its last
//   beat is accepted. One registered output stage feeds the sink.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : stream_rr_arbiter_if.slave (requests, grants, output beat, busy)
module stream_rr_arbiter #(
  parameter int BIT_DEPTH = 8,
  parameter int T_AMOUNT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  stream_rr_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(T_AMOUNT);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     gnt, gnt_nxt;
  logic [IDX_W-1:0]     ptr, ptr_nxt;

  logic                 vld_p1;
  logic [BIT_DEPTH-1:0] data_p1;
  logic                 last_p1;
  logic [T_AMOUNT-1:0]  num_p1;

  logic [IDX_W:0]       pick;
  logic [T_AMOUNT-1:0]  ready;
  logic [T_AMOUNT-1:0]  gnt_onehot;
  logic                 slot_free;
  logic                 accept;

  // Returns {found, index}: first set request searching start, start+1, ...
  // with wrap modulo T_AMOUNT (works for non-power-of-two counts).
  function automatic logic [IDX_W:0] rr_pick(input logic [T_AMOUNT-1:0] req,
                                             input logic [IDX_W-1:0]    start);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < T_AMOUNT; i++) begin
      cand = (int'(start) + i) % T_AMOUNT;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  // Explicit wrap so T_AMOUNT need not be a power of two.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
    return (cur == IDX_W'(T_AMOUNT - 1)) ? '0 : cur + IDX_W'(1);
  endfunction

  always_comb begin
    pick            = rr_pick(bus.t_valid_i, ptr);
    gnt_onehot      = '0;
    gnt_onehot[gnt] = 1'b1;
    // The output slot can take a beat when empty or draining this cycle.
    slot_free       = !vld_p1 || bus.t_ready_i;
    ready           = '0;
    accept          = 1'b0;
    state_nxt       = state;
    gnt_nxt         = gnt;
    ptr_nxt         = ptr;
    case (state)
      IDLE: begin
        if (pick[IDX_W]) begin
          gnt_nxt   = pick[IDX_W-1:0];
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        ready[gnt] = slot_free;
        accept     = bus.t_valid_i[gnt] && slot_free;
        if (accept && bus.t_last_i[gnt]) begin
          ptr_nxt   = next_idx(gnt);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // ---- stage p1: registered output beat ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      num_p1  <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= bus.t_data_i[gnt];
      last_p1 <= bus.t_last_i[gnt];
      num_p1  <= gnt_onehot;
    end else if (vld_p1 && bus.t_ready_i) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.t_ready_o  = ready;
  assign bus.t_data_o   = data_p1;
  assign bus.t_valid_o  = vld_p1;
  assign bus.t_last_o   = last_p1;
  assign bus.t_number_o = num_p1;
  assign bus.busy_o     = (state == BUSY);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;
  localparam int BIT_DEPTH = 8;
  localparam int T_AMOUNT  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_rr_arbiter_if #(.BIT_DEPTH(BIT_DEPTH), .T_AMOUNT(T_AMOUNT)) bus ();
  stream_rr_arbiter #(.BIT_DEPTH(BIT_DEPTH), .T_AMOUNT(T_AMOUNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Per-requester beat queues ({last, data}), head/tail counters.
  logic [8:0] bq [T_AMOUNT][256];
  int hd  [T_AMOUNT];
  int tl  [T_AMOUNT];
  int gap [T_AMOUNT];
  bit fair_mode = 1'b0;
  bit rnd_mode  = 1'b0;

  // Behavioural model: owner (-1 = nobody), pointer, output beat.
  bit         m_known = 1'b0;
  int         m_own   = -1;
  int         m_ptr   = 0;
  bit         m_ov    = 1'b0;
  logic [7:0] m_od    = '0;
  bit         m_ol    = 1'b0;
  logic [3:0] m_on    = '0;

  // Log of beats taken by the sink.
  logic [7:0] lg_d [512];
  logic [3:0] lg_n [512];
  logic       lg_l [512];
  int         lg_c [512];
  int         lg_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    bq[k][tl[k] % 256] = {l, d};
    tl[k]++;
  endtask

  task automatic clear_queues();
    for (int k = 0; k < T_AMOUNT; k++) begin
      hd[k]  = tl[k];
      gap[k] = 0;
    end
  endtask

  task automatic drive_inputs();
    logic [8:0] e;
    int len;
    for (int k = 0; k < T_AMOUNT; k++) begin
      if (fair_mode && tl[k] == hd[k]) push(k, 8'h10 + 8'(k), 1'b1);
      if (rnd_mode && tl[k] == hd[k] && gap[k] == 0 && $urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) push(k, 8'($urandom), (b == len - 1));
      end
      if (tl[k] != hd[k]) begin
        e = bq[k][hd[k] % 256];
        bus.t_valid_i[k] = (gap[k] == 0);
        bus.t_data_i[k]  = e[7:0];
        bus.t_last_i[k]  = e[8];
      end else begin
        bus.t_valid_i[k] = 1'b0;
        bus.t_data_i[k]  = '0;
        bus.t_last_i[k]  = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive, compare DUT against the model, advance both.
  task automatic step();
    logic [3:0] er;
    bit acc;
    bit fire;
    int pick;
    int own;
    drive_inputs();
    #1;
    er = '0;
    if (m_own >= 0 && (!m_ov || bus.t_ready_i)) er[m_own] = 1'b1;
    if (m_known) begin
      chk("t_ready_o",  bus.t_ready_o,  er);
      chk("t_valid_o",  bus.t_valid_o,  m_ov);
      chk("t_data_o",   bus.t_data_o,   m_od);
      chk("t_last_o",   bus.t_last_o,   m_ol);
      chk("t_number_o", bus.t_number_o, m_on);
      chk("busy_o",     bus.busy_o,     (m_own >= 0));
      if (!rst && bus.t_valid_o === 1'b1 && bus.t_ready_i === 1'b1 && lg_cnt < 512) begin
        lg_d[lg_cnt] = bus.t_data_o;
        lg_n[lg_cnt] = bus.t_number_o;
        lg_l[lg_cnt] = bus.t_last_o;
        lg_c[lg_cnt] = cyc;
        lg_cnt++;
      end
    end
    own  = m_own;
    acc  = !rst && (own >= 0) && er[own] && bus.t_valid_i[own];
    fire = m_ov && bus.t_ready_i;
    if (rst) begin
      m_known = 1'b1;
      m_own = -1; m_ptr = 0; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_on = '0;
    end else if (own < 0) begin
      pick = -1;
      for (int i = 0; i < T_AMOUNT; i++)
        if (pick < 0 && bus.t_valid_i[(m_ptr + i) % T_AMOUNT]) pick = (m_ptr + i) % T_AMOUNT;
      m_own = pick;
      if (fire) m_ov = 1'b0;
    end else if (acc) begin
      m_od = bus.t_data_i[own];
      m_ol = bus.t_last_i[own];
      m_on = 4'b0001 << own;
      m_ov = 1'b1;
      if (bus.t_last_i[own]) begin
        m_ptr = (own + 1) % T_AMOUNT;
        m_own = -1;
      end
    end else if (fire) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < T_AMOUNT; k++) if (gap[k] > 0) gap[k]--;
    if (acc) begin
      hd[own]++;
      if (rnd_mode && $urandom_range(0, 3) == 0) gap[own] = $urandom_range(1, 3);
    end
  endtask

  task automatic run_until_log(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (lg_cnt < n && c < budget) begin
      step();
      c++;
    end
    chk(name, (lg_cnt >= n), 1);
  endtask

  task automatic quiet();
    bus.t_ready_i = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int k = 0; k < T_AMOUNT; k++) begin
      hd[k] = 0; tl[k] = 0; gap[k] = 0;
    end
    bus.t_ready_i = 1'b1;

    // Reset with every requester valid, then continuous 1-beat packets.
    fair_mode = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk("rst_t_valid_o",  bus.t_valid_o,  0);
    chk("rst_t_data_o",   bus.t_data_o,   0);
    chk("rst_t_last_o",   bus.t_last_o,   0);
    chk("rst_t_number_o", bus.t_number_o, 0);
    chk("rst_t_ready_o",  bus.t_ready_o,  0);
    chk("rst_busy_o",     bus.busy_o,     0);
    rst = 1'b0;
    lg_cnt = 0;
    step();
    chk("first_grant", bus.t_ready_o, 4'b0001);
    run_until_log(8, 40, "fair_timeout");
    for (int i = 0; i < 8; i++) begin
      chk("fair_number", lg_n[i], 4'b0001 << (i % 4));
      chk("fair_data",   lg_d[i], 8'h10 + 8'(i % 4));
      if (i > 0) chk("fair_spacing", lg_c[i] - lg_c[i-1], 2);
    end
    fair_mode = 1'b0;
    clear_queues();
    rst = 1'b1;
    step();
    rst = 1'b0;
    quiet();

    // Packet lock: requester 2 sends A0..A2, requester 1 joins later.
    lg_cnt = 0;
    push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
    step();
    push(1, 8'h51, 1'b1);
    run_until_log(4, 30, "lock_timeout");
    chk("lock_d0", lg_d[0], 8'hA0); chk("lock_n0", lg_n[0], 4'b0100); chk("lock_l0", lg_l[0], 0);
    chk("lock_d1", lg_d[1], 8'hA1); chk("lock_n1", lg_n[1], 4'b0100); chk("lock_l1", lg_l[1], 0);
    chk("lock_d2", lg_d[2], 8'hA2); chk("lock_n2", lg_n[2], 4'b0100); chk("lock_l2", lg_l[2], 1);
    chk("lock_d3", lg_d[3], 8'h51); chk("lock_n3", lg_n[3], 4'b0010); chk("lock_l3", lg_l[3], 1);
    quiet();

    // Backpressure mid-packet.
    lg_cnt = 0;
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b0); push(1, 8'hB3, 1'b1);
    step();
    step();
    step();
    bus.t_ready_i = 1'b0;
    repeat (5) begin
      step();
      chk("bp_hold_data",  bus.t_data_o,  8'hB1);
      chk("bp_hold_valid", bus.t_valid_o, 1);
      chk("bp_ready_low",  bus.t_ready_o, 0);
    end
    bus.t_ready_i = 1'b1;
    run_until_log(4, 20, "bp_timeout");
    repeat (4) step();
    chk("bp_count", lg_cnt, 4);
    for (int i = 0; i < 4; i++) chk("bp_data", lg_d[i], 8'hB0 + 8'(i));
    chk("bp_b2b_1", lg_c[2] - lg_c[1], 1);
    chk("bp_b2b_2", lg_c[3] - lg_c[2], 1);
    quiet();

    // Gap inside a packet: requester 0 stalls, requester 3 waits.
    lg_cnt = 0;
    push(0, 8'hC0, 1'b0);
    step();
    push(3, 8'hD0, 1'b1);
    step();
    repeat (3) begin
      step();
      chk("gap_busy",  bus.busy_o,    1);
      chk("gap_ready", bus.t_ready_o, 4'b0001);
    end
    push(0, 8'hC1, 1'b1);
    run_until_log(3, 20, "gap_timeout");
    chk("gap_d0", lg_d[0], 8'hC0); chk("gap_n0", lg_n[0], 4'b0001);
    chk("gap_d1", lg_d[1], 8'hC1); chk("gap_n1", lg_n[1], 4'b0001);
    chk("gap_d2", lg_d[2], 8'hD0); chk("gap_n2", lg_n[2], 4'b1000);
    quiet();

    // Reset mid-packet: move the pointer to 3 first, then abort a packet.
    lg_cnt = 0;
    push(2, 8'hE0, 1'b1);
    run_until_log(1, 10, "rstmid_e0_timeout");
    quiet();
    push(2, 8'hF0, 1'b0); push(2, 8'hF1, 1'b0); push(2, 8'hF2, 1'b0); push(2, 8'hF3, 1'b1);
    c = 0;
    while (!(bus.t_valid_o === 1'b1 && bus.t_data_o === 8'hF1) && c < 20) begin
      step();
      c++;
    end
    chk("rstmid_reach", (bus.t_valid_o === 1'b1 && bus.t_data_o === 8'hF1), 1);
    clear_queues();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_valid", bus.t_valid_o, 0);
    chk("rstmid_busy",  bus.busy_o,    0);
    push(0, 8'h60, 1'b1);
    push(3, 8'h63, 1'b1);
    step();
    chk("rstmid_ptr0", bus.t_ready_o, 4'b0001);
    quiet();
    quiet();

    // Randomised traffic against the model.
    lg_cnt = 0;
    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.t_ready_i = ($urandom_range(0, 9) < 7);
      step();
    end
    rnd_mode = 1'b0;
    bus.t_ready_i = 1'b1;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
